// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode encodings, initial patterns, default limits and pattern step helpers
package led_ctrl_pkg;
   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_COUNT = 2'd3
   } mode_e;

   localparam logic [3:0] PASS_INIT  = 4'b0000;
   localparam logic [3:0] CHASE_INIT = 4'b0001;
   localparam logic [3:0] BLINK_INIT = 4'b0000;
   localparam logic [3:0] COUNT_INIT = 4'b0000;

   localparam int DEF_DEBOUNCE_LIMIT = 250000;
   localparam int DEF_STEP_LIMIT     = 6250000;

   function automatic logic [3:0] init_pattern(input mode_e m);
      return m == MODE_CHASE ? CHASE_INIT :
             m == MODE_BLINK ? BLINK_INIT :
             m == MODE_COUNT ? COUNT_INIT : PASS_INIT;
   endfunction

   function automatic logic [3:0] step_pattern(input mode_e m, input logic rev, input logic [3:0] p);
      return m == MODE_CHASE ? (rev ? {p[0], p[3:1]} : {p[2:0], p[3]}) :
             m == MODE_BLINK ? ~p :
             m == MODE_COUNT ? (rev ? p - 4'd1 : p + 4'd1) : p;
   endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: 2-flop synchronizer followed by a hold-time debounce for one switch
module debounce_filter
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_switch,
   output logic o_db
);
   localparam int CW = $clog2(DEBOUNCE_LIMIT);

   logic           sync1_q, sync2_q, db_q, db_d, hit;
   logic [CW-1:0]  cnt_q, cnt_d;

   always_comb begin
      hit   = (sync2_q != db_q) && (cnt_q == CW'(DEBOUNCE_LIMIT - 1));
      cnt_d = (sync2_q == db_q || hit) ? '0 : cnt_q + CW'(1);
      db_d  = hit ? sync2_q : db_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= i_switch;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_db = db_q;
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: debounced switch presses drive a four-mode LED pattern engine
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
   parameter int STEP_LIMIT     = DEF_STEP_LIMIT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_switch_0,
   input  logic       i_switch_1,
   input  logic       i_switch_2,
   input  logic       i_switch_3,
   output logic       o_led_0,
   output logic       o_led_1,
   output logic       o_led_2,
   output logic       o_led_3,
   output logic [1:0] o_mode
);
   localparam int SW = $clog2(STEP_LIMIT);

   logic [3:0]    sw_raw, sw_db, sw_dly_q, press, pat_q, pat_d, led;
   logic [SW-1:0] step_q, step_d;
   logic          pause_q, pause_d, dir_q, dir_d, run, tick;
   mode_e         mode_q, mode_d;

   assign sw_raw = {i_switch_3, i_switch_2, i_switch_1, i_switch_0};

   for (genvar n = 0; n < 4; n++) begin : g_db
      debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_switch (sw_raw[n]),
         .o_db     (sw_db[n])
      );
   end

   assign press = sw_db & ~sw_dly_q;
   assign run   = (mode_q != MODE_PASS) && !pause_q;
   assign tick  = run && (step_q == SW'(STEP_LIMIT - 1));

   // mode advance beats restart beats tick; toggles only survive when neither fires
   always_comb begin
      mode_d  = mode_q;
      pause_d = pause_q;
      dir_d   = dir_q;
      step_d  = step_q;
      pat_d   = pat_q;
      if (press[3]) begin
         mode_d  = mode_e'(mode_q + 2'd1);
         pause_d = 1'b0;
         dir_d   = 1'b0;
         step_d  = '0;
         pat_d   = init_pattern(mode_d);
      end else if (press[0] && mode_q != MODE_PASS) begin
         step_d = '0;
         pat_d  = init_pattern(mode_q);
      end else if (mode_q != MODE_PASS) begin
         step_d  = !run ? step_q : tick ? '0 : step_q + SW'(1);
         pat_d   = tick ? step_pattern(mode_q, dir_q, pat_q) : pat_q;
         pause_d = pause_q ^ press[2];
         dir_d   = dir_q ^ press[1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         mode_q   <= MODE_PASS;
         pause_q  <= 1'b0;
         dir_q    <= 1'b0;
         step_q   <= '0;
         pat_q    <= PASS_INIT;
         sw_dly_q <= '0;
      end else begin
         mode_q   <= mode_d;
         pause_q  <= pause_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         pat_q    <= pat_d;
         sw_dly_q <= sw_db;
      end
   end

   assign led     = (mode_q == MODE_PASS) ? sw_db : pat_q;
   assign o_led_0 = led[0];
   assign o_led_1 = led[1];
   assign o_led_2 = led[2];
   assign o_led_3 = led[3];
   assign o_mode  = mode_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed and random switch activity checked every cycle against a behavioural model
module tb_led_pattern_ctrl;
   localparam int DL = 4;
   localparam int SL = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw = 4'b0000;
   logic       l0, l1, l2, l3;
   logic [1:0] mode;
   logic [3:0] led;

   int checks = 0;
   int errors = 0;
   int ncyc = 0;

   logic [3:0] h [0:DL];
   logic [3:0] m_db, m_prev;
   int         m_mode, m_run, m_pos, m_cnt;
   logic       m_pause, m_dir, m_on;

   always #5 clk = ~clk;

   led_pattern_ctrl #(.DEBOUNCE_LIMIT(DL), .STEP_LIMIT(SL)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_switch_0 (sw[0]),
      .i_switch_1 (sw[1]),
      .i_switch_2 (sw[2]),
      .i_switch_3 (sw[3]),
      .o_led_0    (l0),
      .o_led_1    (l1),
      .o_led_2    (l2),
      .o_led_3    (l3),
      .o_mode     (mode)
   );

   assign led = {l3, l2, l1, l0};

   function automatic logic [3:0] exp_led();
      return m_mode == 0 ? m_db :
             m_mode == 1 ? 4'(1 << m_pos) :
             m_mode == 2 ? {4{m_on}} : 4'(m_cnt);
   endfunction

   task automatic restart_pattern();
      m_run = 0;
      m_pos = 0;
      m_on  = 1'b0;
      m_cnt = 0;
   endtask

   // one clock edge of the model: a switch level is accepted once the synced
   // samples have shown the opposite value for DL consecutive edges
   task automatic model_edge();
      logic [3:0] nd, pr;
      logic       flip, tk;
      if (!rst_n) begin
         for (int k = 0; k <= DL; k++) h[k] = 4'b0000;
         m_db = 4'b0000;
         m_prev = 4'b0000;
         m_mode = 0;
         m_pause = 1'b0;
         m_dir = 1'b0;
         restart_pattern();
      end else begin
         nd = m_db;
         for (int n = 0; n < 4; n++) begin
            flip = 1'b1;
            for (int k = 1; k <= DL; k++) if (h[k][n] == m_db[n]) flip = 1'b0;
            if (flip) nd[n] = ~m_db[n];
         end
         pr = m_db & ~m_prev;
         tk = m_mode != 0 && !m_pause && (m_run % SL == SL - 1);
         if (pr[3]) begin
            m_mode = (m_mode + 1) % 4;
            m_pause = 1'b0;
            m_dir = 1'b0;
            restart_pattern();
         end else if (pr[0] && m_mode != 0) begin
            restart_pattern();
         end else if (m_mode != 0) begin
            if (!m_pause) m_run++;
            if (tk) begin
               m_pos = m_dir ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
               m_on  = !m_on;
               m_cnt = m_dir ? (m_cnt + 15) % 16 : (m_cnt + 1) % 16;
            end
            if (pr[2]) m_pause = !m_pause;
            if (pr[1]) m_dir = !m_dir;
         end
         for (int k = DL; k >= 1; k--) h[k] = h[k-1];
         h[0] = sw;
         m_prev = m_db;
         m_db = nd;
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, ncyc, got, exp);
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      ncyc++;
      chk("led", led, exp_led());
      chk("mode", {2'b00, mode}, 4'(m_mode));
   endtask

   task automatic hold(input logic [3:0] v, input int n);
      sw = v;
      repeat (n) cyc();
   endtask

   initial begin
      logic [3:0] msk;
      int r;
      repeat (2) cyc();
      chk("reset_led", led, 4'b0000);
      chk("reset_mode", {2'b00, mode}, 4'd0);
      rst_n = 1'b1;
      hold(4'b0010, 5);
      chk("db_latency_early", {3'b000, l1}, 4'd0);
      cyc();
      chk("db_latency", {3'b000, l1}, 4'd1);
      hold(4'b0000, 8);
      hold(4'b1000, 2);
      hold(4'b0000, 10);
      chk("glitch_mode", {2'b00, mode}, 4'd0);
      hold(4'b1000, 10);
      chk("chase_mode", {2'b00, mode}, 4'd1);
      chk("chase_init", led, 4'b0001);
      hold(4'b0000, 40);
      hold(4'b1000, 8);
      hold(4'b0000, 8);
      hold(4'b1000, 8);
      hold(4'b0000, 8);
      chk("count_mode", {2'b00, mode}, 4'd3);
      hold(4'b0010, 8);
      sw = 4'b0000;
      for (int i = 0; i < 120 && led !== 4'hF; i++) cyc();
      chk("count_rev_wrap", led, 4'hF);
      hold(4'b0010, 8);
      sw = 4'b0000;
      for (int i = 0; i < 160 && led !== 4'h0; i++) cyc();
      chk("count_fwd_wrap", led, 4'h0);
      hold(4'b1001, 8);
      chk("adv_restart_mode", {2'b00, mode}, 4'd0);
      hold(4'b0000, 8);
      for (int s = 0; s < 320; s++) begin
         r = $urandom_range(0, 9);
         msk = r < 4 ? 4'(1 << r) : r == 4 ? 4'($urandom_range(0, 15)) : 4'b0000;
         hold(msk, $urandom_range(1, 14));
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            cyc();
            chk("mid_reset_led", led, 4'b0000);
            chk("mid_reset_mode", {2'b00, mode}, 4'd0);
            rst_n = 1'b1;
         end
      end
      hold(4'b0000, 12);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
